// File: rtl/uart_stack_initiator.sv
// Stack-echo initiator: sends DEPTH pattern bytes, checks the reversed reply.
// Optional rx idle timeout is built when UART_STACK_INIT_TIMEOUT_EN is defined.
module uart_stack_initiator #(
  parameter int          PAYLOAD_BITS = 8,
  parameter int          DEPTH        = 64,
  parameter int          SKIP_FIRST   = 1,
  parameter int unsigned SEED         = 'h30
`ifdef UART_STACK_INIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
`endif
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_count,
  output logic [7:0]              first_err_idx,
`ifdef UART_STACK_INIT_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy,
  input  logic                    uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    uart_rx_break
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(SKIP_FIRST + DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    HOLD,
    RECV,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           i, i_n;
  logic [RW-1:0]           r, r_n, j;
  logic [7:0]              err_n, fe_n;
  logic [PAYLOAD_BITS-1:0] data_n, exp_byte;
  logic                    tx_en_n;
  logic                    abort, abort_n;
  logic                    fail_n;

`ifdef UART_STACK_INIT_TIMEOUT_EN
  logic [31:0] idle_cnt, idle_n;
  logic        to_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      idle_cnt <= idle_n;
      timeout  <= to_n;
    end
  end

  assign fail_n = abort_n | to_n;
`else
  assign fail_n = abort_n;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      i             <= '0;
      r             <= '0;
      err_count     <= '0;
      first_err_idx <= 8'hFF;
      uart_tx_en    <= 1'b0;
      uart_tx_data  <= '0;
      abort         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state         <= state_n;
      i             <= i_n;
      r             <= r_n;
      err_count     <= err_n;
      first_err_idx <= fe_n;
      uart_tx_en    <= tx_en_n;
      uart_tx_data  <= data_n;
      abort         <= abort_n;
      busy          <= (state_n == SEND) || (state_n == HOLD) ||
                       (state_n == RECV);
      done          <= (state_n == DONE);
      pass          <= (state_n == DONE) && (err_n == 8'd0) && !fail_n;
    end
  end

  always_comb begin
    state_n  = state;
    i_n      = i;
    r_n      = r;
    err_n    = err_count;
    fe_n     = first_err_idx;
    tx_en_n  = 1'b0;
    data_n   = uart_tx_data;
    abort_n  = abort;
    j        = r - RW'(SKIP_FIRST);
    exp_byte = PAYLOAD_BITS'(SEED + DEPTH - 1) - PAYLOAD_BITS'(j);
`ifdef UART_STACK_INIT_TIMEOUT_EN
    idle_n   = idle_cnt;
    to_n     = timeout;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SEND;
          i_n     = '0;
          r_n     = '0;
          err_n   = '0;
          fe_n    = 8'hFF;
          abort_n = 1'b0;
`ifdef UART_STACK_INIT_TIMEOUT_EN
          to_n    = 1'b0;
`endif
        end
      end
      SEND: begin
        if (uart_rx_valid && err_count != 8'hFF)
          err_n = err_count + 8'd1;
        if (!uart_tx_busy) begin
          tx_en_n = 1'b1;
          data_n  = PAYLOAD_BITS'(SEED) + PAYLOAD_BITS'(i);
          i_n     = i + IW'(1);
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (uart_rx_valid && err_count != 8'hFF)
          err_n = err_count + 8'd1;
        // Wait for the core to take the byte so one request is never sent twice
        if (uart_tx_busy) begin
          state_n = (i == IW'(DEPTH)) ? RECV : SEND;
`ifdef UART_STACK_INIT_TIMEOUT_EN
          idle_n  = '0;
`endif
        end
      end
      RECV: begin
`ifdef UART_STACK_INIT_TIMEOUT_EN
        idle_n = idle_cnt + 32'd1;
        if (!uart_rx_valid && idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
          state_n = DONE;
          to_n    = 1'b1;
        end
`endif
        if (uart_rx_valid) begin
          r_n = r + RW'(1);
`ifdef UART_STACK_INIT_TIMEOUT_EN
          idle_n = '0;
`endif
          if (r >= RW'(SKIP_FIRST)) begin
            if (uart_rx_data != exp_byte) begin
              if (err_count != 8'hFF)
                err_n = err_count + 8'd1;
              if (first_err_idx == 8'hFF)
                fe_n = 8'(j);
            end
            if (j == RW'(DEPTH - 1))
              state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (uart_rx_break &&
        (state == SEND || state == HOLD || state == RECV)) begin
      state_n = DONE;
      abort_n = 1'b1;
      tx_en_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_stack_initiator.sv
// Randomized bench for uart_stack_initiator with uart_tx/responder models.
// Timeout scenario is built when UART_STACK_INIT_TIMEOUT_EN is defined.
module tb_uart_stack_initiator;

  localparam int          DEPTH = 4;
  localparam int          SKIP  = 1;
  localparam int unsigned SEED  = 'h30;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_idx;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rx_break = 1'b0;
`ifdef UART_STACK_INIT_TIMEOUT_EN
  logic       timeout;
`endif

  int   n_checks = 0;
  int   n_errs = 0;
  int   busy_cnt = 0;
  logic bp_hold = 1'b0;
  bq_t  tx_q;
  int   tx_viol = 0;
  int   cyc = 0;
  bit   hung;
  int   bp_seen;
  int   t_last, t_done;

  uart_stack_initiator #(
    .PAYLOAD_BITS(8),
    .DEPTH(DEPTH),
    .SKIP_FIRST(SKIP),
    .SEED(SEED)
`ifdef UART_STACK_INIT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_err_idx(first_err_idx),
`ifdef UART_STACK_INIT_TIMEOUT_EN
    .timeout(timeout),
`endif
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: each accepted byte keeps the core busy for 10 cycles
  assign uart_tx_busy = (busy_cnt != 0) || bp_hold;

  always @(negedge clk) begin
    if (uart_tx_en) begin
      if (uart_tx_busy) tx_viol++;
      tx_q.push_back(uart_tx_data);
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  function automatic bq_t good_reply(input logic [7:0] lead);
    bq_t q;
    q.push_back(lead);
    for (int k = 0; k < DEPTH; k++) q.push_back(8'(SEED + DEPTH - 1 - k));
    return q;
  endfunction

  // Reference: skip lead bytes, compare reply[j] against the reversed pattern
  function automatic void ref_run(input bq_t reply, input int extra,
                                  input bit abrt, output int e,
                                  output logic [7:0] fe, output bit p);
    int jj;
    logic [7:0] want;
    e  = extra;
    fe = 8'hFF;
    for (int k = SKIP; k < reply.size(); k++) begin
      jj   = k - SKIP;
      want = 8'(SEED + DEPTH - 1 - jj);
      if (reply[k] !== want) begin
        if (e < 255) e++;
        if (fe == 8'hFF) fe = 8'(jj);
      end
    end
    p = (e == 0) && !abrt;
  endfunction

  task automatic wait_tx_idle();
    int g = 0;
    while (uart_tx_busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (uart_tx_busy) hung = 1;
  endtask

  task automatic drive_run(input bq_t reply, input bit early, input int bp,
                           input bit both, input int brk_at);
    int g;
    bit early_done = 0;
    hung    = 0;
    bp_seen = 0;
    wait_tx_idle();
    tx_q.delete();
    tx_viol = 0;
    @(negedge clk);
    bp_hold = (bp > 0);
    start   = 1'b1;
    if (both) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'($urandom);
    end
    @(negedge clk);
    start         = 1'b0;
    uart_rx_valid = 1'b0;
    repeat (bp) @(negedge clk);
    bp_seen = tx_q.size();
    bp_hold = 1'b0;
    g = 0;
    while (tx_q.size() < DEPTH && g < 2000) begin
      if (early && !early_done && tx_q.size() == 1) begin
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'($urandom);
        early_done    = 1;
      end else begin
        uart_rx_valid = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    uart_rx_valid = 1'b0;
    if (tx_q.size() < DEPTH) hung = 1;
    wait_tx_idle();
    for (int k = 0; k < reply.size(); k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (k == brk_at) begin
        uart_rx_break = 1'b1;
        @(negedge clk);
        uart_rx_break = 1'b0;
        break;
      end
      uart_rx_valid = 1'b1;
      uart_rx_data  = reply[k];
      t_last        = cyc;
      @(negedge clk);
      uart_rx_valid = 1'b0;
    end
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    t_done = cyc;
    if (!done) hung = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (busy !== 1'b0) begin n_errs++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_errs++; $display("FAIL reset done: got %b want 0", done); end
    if (pass !== 1'b0) begin n_errs++; $display("FAIL reset pass: got %b want 0", pass); end
    if (uart_tx_en !== 1'b0) begin n_errs++; $display("FAIL reset tx_en: got %b want 0", uart_tx_en); end
    if (uart_tx_data !== 8'h00) begin n_errs++; $display("FAIL reset tx_data: got %h want 00", uart_tx_data); end
    if (err_count !== 8'h00) begin n_errs++; $display("FAIL reset err_count: got %h want 00", err_count); end
    if (first_err_idx !== 8'hFF) begin n_errs++; $display("FAIL reset first_err_idx: got %h want ff", first_err_idx); end
`ifdef UART_STACK_INIT_TIMEOUT_EN
    n_checks++;
    if (timeout !== 1'b0) begin n_errs++; $display("FAIL reset timeout: got %b want 0", timeout); end
`endif
  endtask

  task automatic test_basic();
    bq_t rep;
    int e;
    logic [7:0] fe, got, want;
    bit p;
    rep = good_reply(8'h99);
    ref_run(rep, 0, 0, e, fe, p);
    drive_run(rep, 0, 0, 0, -1);
    n_checks += 7;
    if (hung) begin n_errs++; $display("FAIL basic run: did not complete"); end
    if (tx_q.size() != DEPTH) begin n_errs++; $display("FAIL basic tx count: got %0d want %0d", tx_q.size(), DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      want = 8'(SEED + k);
      got  = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
      n_checks++;
      if (got !== want) begin n_errs++; $display("FAIL basic tx[%0d]: got %h want %h", k, got, want); end
    end
    if (done !== 1'b1) begin n_errs++; $display("FAIL basic done: got %b want 1", done); end
    if (pass !== p) begin n_errs++; $display("FAIL basic pass: got %b want %b", pass, p); end
    if (err_count !== 8'(e)) begin n_errs++; $display("FAIL basic err_count: got %0d want %0d", err_count, e); end
    if (first_err_idx !== fe) begin n_errs++; $display("FAIL basic first_err_idx: got %h want %h", first_err_idx, fe); end
    if (busy !== 1'b0) begin n_errs++; $display("FAIL basic busy at done: got %b want 0", busy); end
  endtask

  task automatic test_corrupt();
    bq_t rep;
    int e, n;
    logic [7:0] fe;
    bit p;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        rep = '{8'h99, 8'h33, 8'h32, 8'h00, 8'h30};
      end else begin
        rep = good_reply(8'($urandom));
        n   = $urandom_range(1, 3);
        repeat (n) rep[$urandom_range(1, DEPTH)] = 8'($urandom);
      end
      ref_run(rep, 0, 0, e, fe, p);
      drive_run(rep, 0, 0, 0, -1);
      n_checks += 5;
      if (hung) begin n_errs++; $display("FAIL corrupt%0d run: did not complete", it); end
      if (done !== 1'b1) begin n_errs++; $display("FAIL corrupt%0d done: got %b want 1", it, done); end
      if (pass !== p) begin n_errs++; $display("FAIL corrupt%0d pass: got %b want %b", it, pass, p); end
      if (err_count !== 8'(e)) begin n_errs++; $display("FAIL corrupt%0d err_count: got %0d want %0d", it, err_count, e); end
      if (first_err_idx !== fe) begin n_errs++; $display("FAIL corrupt%0d first_err_idx: got %h want %h", it, first_err_idx, fe); end
    end
  endtask

  task automatic test_back_pressure();
    bq_t rep;
    logic [7:0] got, want;
    rep = good_reply(8'($urandom));
    drive_run(rep, 0, 50, 0, -1);
    n_checks += 5;
    if (hung) begin n_errs++; $display("FAIL bp run: did not complete"); end
    if (bp_seen != 0) begin n_errs++; $display("FAIL bp tx while held: got %0d want 0", bp_seen); end
    if (tx_viol != 0) begin n_errs++; $display("FAIL bp tx_en while busy: got %0d want 0", tx_viol); end
    if (tx_q.size() != DEPTH) begin n_errs++; $display("FAIL bp tx count: got %0d want %0d", tx_q.size(), DEPTH); end
    if (pass !== 1'b1) begin n_errs++; $display("FAIL bp pass: got %b want 1", pass); end
    for (int k = 0; k < DEPTH; k++) begin
      want = 8'(SEED + k);
      got  = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
      n_checks++;
      if (got !== want) begin n_errs++; $display("FAIL bp tx[%0d]: got %h want %h", k, got, want); end
    end
  endtask

  task automatic test_early_rx();
    bq_t rep;
    int e;
    logic [7:0] fe;
    bit p;
    rep = good_reply(8'($urandom));
    ref_run(rep, 1, 0, e, fe, p);
    drive_run(rep, 1, 0, 0, -1);
    n_checks += 5;
    if (hung) begin n_errs++; $display("FAIL early run: did not complete"); end
    if (done !== 1'b1) begin n_errs++; $display("FAIL early done: got %b want 1", done); end
    if (pass !== p) begin n_errs++; $display("FAIL early pass: got %b want %b", pass, p); end
    if (err_count !== 8'(e)) begin n_errs++; $display("FAIL early err_count: got %0d want %0d", err_count, e); end
    if (first_err_idx !== fe) begin n_errs++; $display("FAIL early first_err_idx: got %h want %h", first_err_idx, fe); end
  endtask

  task automatic test_back_to_back();
    bq_t rep;
    for (int it = 0; it < 2; it++) begin
      rep = good_reply(8'($urandom));
      drive_run(rep, 0, 0, 1, -1);
      n_checks += 4;
      if (hung) begin n_errs++; $display("FAIL b2b%0d run: did not complete", it); end
      if (pass !== 1'b1) begin n_errs++; $display("FAIL b2b%0d pass: got %b want 1", it, pass); end
      if (err_count !== 8'h00) begin n_errs++; $display("FAIL b2b%0d err_count: got %0d want 0", it, err_count); end
      if (tx_q.size() != DEPTH) begin n_errs++; $display("FAIL b2b%0d tx count: got %0d want %0d", it, tx_q.size(), DEPTH); end
    end
  endtask

  task automatic test_break_reset();
    bq_t rep;
    int g, q0;
    rep = good_reply(8'($urandom));
    drive_run(rep, 0, 0, 0, 2);
    n_checks += 4;
    if (hung) begin n_errs++; $display("FAIL break run: did not complete"); end
    if (done !== 1'b1) begin n_errs++; $display("FAIL break done: got %b want 1", done); end
    if (pass !== 1'b0) begin n_errs++; $display("FAIL break pass: got %b want 0", pass); end
    if (err_count !== 8'h00) begin n_errs++; $display("FAIL break err_count: got %0d want 0", err_count); end
    hung = 0;
    wait_tx_idle();
    tx_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(uart_tx_en && tx_q.size() >= 1) && g < 500) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (!uart_tx_en) begin n_errs++; $display("FAIL rst mid-send: no second tx_en seen"); end
    resetn = 1'b0;
    #1;
    n_checks += 7;
    if (busy !== 1'b0) begin n_errs++; $display("FAIL rst busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_errs++; $display("FAIL rst done: got %b want 0", done); end
    if (pass !== 1'b0) begin n_errs++; $display("FAIL rst pass: got %b want 0", pass); end
    if (uart_tx_en !== 1'b0) begin n_errs++; $display("FAIL rst tx_en: got %b want 0", uart_tx_en); end
    if (uart_tx_data !== 8'h00) begin n_errs++; $display("FAIL rst tx_data: got %h want 00", uart_tx_data); end
    if (err_count !== 8'h00) begin n_errs++; $display("FAIL rst err_count: got %h want 00", err_count); end
    if (first_err_idx !== 8'hFF) begin n_errs++; $display("FAIL rst first_err_idx: got %h want ff", first_err_idx); end
    q0 = tx_q.size();
    repeat (20) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (tx_q.size() != q0) begin n_errs++; $display("FAIL rst tx after reset: got %0d want %0d", tx_q.size(), q0); end
    if (busy !== 1'b0) begin n_errs++; $display("FAIL rst idle busy: got %b want 0", busy); end
  endtask

`ifdef UART_STACK_INIT_TIMEOUT_EN
  task automatic test_timeout();
    bq_t rep;
    int d;
    rep = good_reply(8'($urandom));
    while (rep.size() > 2) void'(rep.pop_back());
    drive_run(rep, 0, 0, 0, -1);
    d = t_done - t_last;
    n_checks += 5;
    if (hung) begin n_errs++; $display("FAIL timeout run: did not complete"); end
    if (timeout !== 1'b1) begin n_errs++; $display("FAIL timeout flag: got %b want 1", timeout); end
    if (done !== 1'b1) begin n_errs++; $display("FAIL timeout done: got %b want 1", done); end
    if (pass !== 1'b0) begin n_errs++; $display("FAIL timeout pass: got %b want 0", pass); end
    if (d < 100 || d > 102) begin n_errs++; $display("FAIL timeout delay: got %0d want 100..102", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_back_pressure();
    test_early_rx();
    test_back_to_back();
    test_break_reset();
`ifdef UART_STACK_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_stack_initiator.md
Name: uart_stack_initiator

Overview:
- Host-side counterpart of the UART stack-echo responder.
- Sends DEPTH bytes of a known pattern through a uart_tx core, then collects the reply through a uart_rx core and checks that it is the same pattern in reverse order.
- Reports pass/fail, an error count and the index of the first mismatch.
- Sits beside the uart_tx/uart_rx instances in a bring-up or self-test top and drives their core-side signals, not the pins.

Parameters:
- PAYLOAD_BITS, 8: width of tx/rx data.
- DEPTH, 64: number of bytes sent and compared; must match the responder's stack depth.
- SKIP_FIRST, 1: number of received bytes discarded before comparison starts (the responder emits a lead byte).
- SEED, 8'h30: value of the first transmitted byte.
- TIMEOUT_CYCLES, 5000000: maximum idle clk cycles between received bytes (only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; ignored unless state is IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE; cleared when the next start is accepted.
- pass  out  1  valid while done=1; 1 when err_count==0 and no abort occurred.
- err_count  out  8  number of mismatching compared bytes, saturates at 255.
- first_err_idx  out  8  compare index of the first mismatch; 8'hFF if none.
- uart_tx_en  out  1  to uart_tx; single-cycle send request.
- uart_tx_data  out  PAYLOAD_BITS  to uart_tx; byte to send.
- uart_tx_busy  in  1  from uart_tx.
- uart_rx_valid  in  1  from uart_rx; single-cycle strobe.
- uart_rx_data  in  PAYLOAD_BITS  from uart_rx.
- uart_rx_break  in  1  from uart_rx.

Behaviour:
Reset values (asynchronous, resetn low):
- State is IDLE.
- busy=0, done=0, pass=0, uart_tx_en=0, uart_tx_data=0.
- err_count=0, first_err_idx=8'hFF.
- All internal counters are 0.
- Reset asserted mid-run aborts immediately with no further tx_en.

State machine (IDLE, SEND, HOLD, RECV, DONE):
- IDLE/DONE: on start, clear err_count and first_err_idx, zero the tx index i and rx count r, clear done and pass, then go to SEND.
- SEND: when uart_tx_busy=0, drive uart_tx_en=1 for exactly one cycle with uart_tx_data = SEED+i (mod 2^PAYLOAD_BITS), increment i, then go to HOLD. uart_tx_data is registered and stable in the tx_en cycle.
- HOLD: wait for uart_tx_busy=1, which prevents a double send. Then:
  - if i==DEPTH, go to RECV;
  - otherwise go to SEND, which waits for busy to fall.
- RECV: each uart_rx_valid increments r.
  - While r<SKIP_FIRST, the byte is discarded.
  - Otherwise it is compared at index j=r-SKIP_FIRST against SEED+(DEPTH-1-j) (mod 2^PAYLOAD_BITS).
  - On mismatch, err_count increments (saturating); if first_err_idx==8'hFF, it is loaded with j.
  - After the compare with j==DEPTH-1, go to DONE in the next cycle.
- DONE: done=1; pass = (err_count==0) and no abort. Any further rx_valid bytes are ignored.

Boundary conditions and rules:
- uart_rx_valid in SEND or HOLD: counts as one error (err_count increments, first_err_idx unchanged); the byte is not compared.
- uart_rx_break high in any active state: abort to DONE with pass=0.
- start while busy: ignored.
- start and rx_valid in the same cycle in DONE: start wins; the byte is ignored.
- DEPTH=1 is legal. SKIP_FIRST=0 is legal.
- No combinational path from inputs to outputs.

Optional Feature:
Macro: UART_STACK_INIT_TIMEOUT_EN
- Defined:
  - A 32-bit idle counter resets on entry to RECV and on every uart_rx_valid, and increments otherwise in RECV.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with pass=0.
  - An extra output, timeout (1 bit), is set in the same cycle as DONE entry and cleared on start; reset value 0.
- Undefined: RECV waits indefinitely; the timeout port and counter do not exist.

Test Plan:
All scenarios use DEPTH=4, SKIP_FIRST=1, SEED=8'h30, a behavioural responder model, and a UART tx model that takes 10 cycles busy per byte.
1. Basic run: pulse start; responder returns 8'h99,33,32,31,30. Required: exactly 4 tx_en pulses with data 30,31,32,33; then done=1, pass=1, err_count=0, first_err_idx=FF.
2. Corruption: replies 99,33,32,00,30. Required: pass=0, err_count=1, first_err_idx=2.
3. Back-pressure: hold uart_tx_busy=1 for 50 cycles before the first byte. Required: no tx_en while busy; a single pulse per byte; byte order unchanged.
4. Early rx: inject rx_valid during SEND. Required: err_count=1 at done and pass=0.
5. Break and reset: assert uart_rx_break in RECV, which must give done=1 with pass=0. Then restart, and drive resetn low mid-SEND, which must return all outputs to their reset values within the same cycle.
6. Timeout (UART_STACK_INIT_TIMEOUT_EN defined, TIMEOUT_CYCLES=100): responder replies only 2 bytes. Required: timeout=1, done=1, pass=0, 100 cycles after the last rx_valid.
